// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: handshake/data bundle between the pipeline and the
// iterative multiply/divide unit.
//   master (pipeline)  : drives start/op/a/b/flush/hi_we/lo_we/wdata,
//                        observes busy/done/div_zero/hi/lo
//   slave  (muldiv)    : the reverse
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush, hi_we, lo_we, wdata,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush, hi_we, lo_we, wdata,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MIPS-style multiply/divide unit owning the
// architectural HI/LO registers. Shift-add multiply and restoring divide,
// one bit per cycle. Sequence: IDLE -> PREP -> RUN (WIDTH cycles) -> FIX ->
// DONE, so a start in cycle 0 yields done/new HI/LO in cycle WIDTH+3.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   bus (slave)    start/op/a/b   launch (op: 00 mult, 01 div, 10 multu, 11 divu)
//                  flush          cancel in-flight op, back to IDLE
//                  hi_we/lo_we/wdata  mthi/mtlo, honoured only while not busy
//                  busy/done      operation in flight / one-cycle result pulse
//                  div_zero       sticky: last divide had a zero divisor
//                  hi/lo          architectural HI/LO
//
// Build option: MULDIV_UNSIGNED_EN enables multu/divu (op[1]); without it
// op[1] is ignored and the 1x codes run signed.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  muldiv_sequencer_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   mag_q, mag_d;       // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q, acc_d;       // {hi part, lo part} working register
  logic               div_q, div_d;
  logic               bz_q, bz_d;         // divisor was zero at launch
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               dz_q, dz_d;

  logic idle_like, accept;

  // DONE behaves like IDLE for new launches and mthi/mtlo.
  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept    = idle_like && bus.start && !bus.flush;

`ifdef MULDIV_UNSIGNED_EN
  logic uns_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      uns_q <= 1'b0;
    else if (accept) uns_q <= bus.op[1];
  end
`else
  logic uns_q;
  logic unused_op1;
  assign uns_q      = 1'b0;
  assign unused_op1 = bus.op[1];
`endif

  // Sign handling for PREP.
  logic             sa, sb;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign sa    = a_q[WIDTH-1] & ~uns_q;
  assign sb    = b_q[WIDTH-1] & ~uns_q;
  assign a_mag = sa ? -a_q : a_q;
  assign b_mag = sb ? -b_q : b_q;

  // Multiply step: conditional add into the upper half, then shift right.
  // The sum keeps its carry so the shift brings it into the top bit.
  logic [WIDTH:0]     msum, mupper;
  logic [2*WIDTH-1:0] mult_nxt;
  assign msum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_q};
  assign mupper   = acc_q[0] ? msum : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
  assign mult_nxt = {mupper, acc_q[WIDTH-1:1]};

  // Divide step: shift {rem, quot} left, trial-subtract with one guard bit.
  // rem < divisor keeps the shifted remainder within WIDTH+1 bits.
  logic [WIDTH:0]     rem_sh, diff;
  logic [2*WIDTH-1:0] div_nxt;
  assign rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign diff    = rem_sh - {1'b0, mag_q};
  assign div_nxt = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};

  // Sign fix-up of the finished result.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  assign prod_fix = neg_lo_q ? -acc_q : acc_q;

  always_comb begin
    fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo = prod_fix[WIDTH-1:0];
    if (div_q) begin
      if (bz_q) begin
        fix_hi = a_q;
        fix_lo = '1;
      end else begin
        fix_lo = neg_lo_q ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
        fix_hi = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      end
    end
  end

  // Next-state / datapath.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    mag_d    = mag_q;
    acc_d    = acc_q;
    div_d    = div_q;
    bz_d     = bz_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;

    // mthi/mtlo first so a result written at the same edge would win;
    // in practice results land from FIX where writes are blocked anyway.
    if (idle_like && bus.hi_we) hi_d = bus.wdata;
    if (idle_like && bus.lo_we) lo_d = bus.wdata;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          state_d = S_PREP;
          a_d     = bus.a;
          b_d     = bus.b;
          div_d   = bus.op[0];
          bz_d    = (bus.b == '0);
          if (bus.op[0] && (bus.b != '0)) dz_d = 1'b0;
        end
      end
      S_PREP: begin
        state_d  = S_RUN;
        cnt_d    = CW'(WIDTH);
        neg_lo_d = sa ^ sb;
        neg_hi_d = sa;
        if (div_q) begin
          mag_d = b_mag;
          acc_d = {{WIDTH{1'b0}}, a_mag};
        end else begin
          mag_d = a_mag;
          acc_d = {{WIDTH{1'b0}}, b_mag};
        end
      end
      S_RUN: begin
        acc_d = div_q ? div_nxt : mult_nxt;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_DONE;
        hi_d    = fix_hi;
        lo_d    = fix_lo;
        if (div_q && bz_q) dz_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush cancels everything in flight, including a same-cycle result.
    if (bus.flush) begin
      state_d = S_IDLE;
      if (state_q == S_FIX) begin
        hi_d = hi_q;
        lo_d = lo_q;
        dz_d = dz_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mag_q    <= '0;
      acc_q    <= '0;
      div_q    <= 1'b0;
      bz_q     <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mag_q    <= mag_d;
      acc_q    <= acc_d;
      div_q    <= div_d;
      bz_q     <= bz_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
    end
  end

  assign bus.busy     = (state_q == S_PREP) || (state_q == S_RUN) || (state_q == S_FIX);
  assign bus.done     = (state_q == S_DONE);
  assign bus.div_zero = dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed vectors for muldiv_sequencer. Each launch
// pushes its hand-computed HI/LO/div_zero and expected done cycle into a
// scoreboard queue; a negedge monitor pops and compares on every done pulse.
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           cyc;
  } exp_t;
  exp_t sbq[$];

  muldiv_sequencer_if #(.WIDTH(W)) bus();
  muldiv_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz);
    exp_t e;
    e.hi = eh; e.lo = el; e.dz = edz; e.cyc = cyc + W + 3;
    sbq.push_back(e);
  endtask

  // Launch in the current cycle; return in the expected done cycle so a
  // following issue() is a back-to-back start.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz,
                       input bit cb);
    bus.start = 1'b1; bus.op = o; bus.a = ai; bus.b = bi;
    push(eh, el, edz);
    for (int k = 1; k <= W + 3; k++) begin
      step();
      if (k == 1) bus.start = 1'b0;
      if (cb) chk("busy_timing", {31'b0, bus.busy}, {31'b0, k < W + 3});
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin : pop_blk
        exp_t e;
        e = sbq.pop_front();
        chk("res_hi", bus.hi, e.hi);
        chk("res_lo", bus.lo, e.lo);
        chk("res_div_zero", {31'b0, bus.div_zero}, {31'b0, e.dz});
        chk("done_cycle", cyc, e.cyc);
        chk("busy_in_done", {31'b0, bus.busy}, '0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.flush = 0;
    bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0;
    repeat (3) step();
    chk("rst_hi", bus.hi, '0);
    chk("rst_lo", bus.lo, '0);
    chk("rst_busy", {31'b0, bus.busy}, '0);
    chk("rst_done", {31'b0, bus.done}, '0);
    chk("rst_dz", {31'b0, bus.div_zero}, '0);
    rst_n = 1'b1;
    step();

    // Load HI/LO, then reset in the middle of RUN.
    bus.hi_we = 1; bus.lo_we = 1; bus.wdata = 32'h0000_0055;
    step();
    bus.hi_we = 0; bus.lo_we = 0;
    chk("mt_lo", bus.lo, 32'h0000_0055);
    bus.start = 1; bus.op = 2'b00; bus.a = 3; bus.b = 5;
    step();
    bus.start = 0;
    repeat (9) step();
    chk("midrun_busy", {31'b0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_hi", bus.hi, '0);
    chk("midrst_lo", bus.lo, '0);
    chk("midrst_busy", {31'b0, bus.busy}, '0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (40) step();

    bus.hi_we = 1; bus.wdata = 32'h0000_1234;
    step();
    bus.hi_we = 0;
    chk("mthi", bus.hi, 32'h0000_1234);

    // Signed mult -2*3 with busy window checked.
    issue(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 1'b1);
    // Signed div -7/2.
    issue(2'b01, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    // Divide by zero then back-to-back 10/3 launched in the done cycle.
    issue(2'b01, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1'b0);
    issue(2'b01, 32'h0000_000A, 32'h0000_0003, 32'h0000_0001, 32'h0000_0003, 1'b0, 1'b0);
    // Signed overflow and a mixed-sign divide.
    issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);
    issue(2'b01, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b0);
    repeat (2) step();

    // mthi in the same cycle as a start: write lands, result overwrites.
    bus.start = 1; bus.op = 2'b00; bus.a = 32'h1234_5678; bus.b = 32'h0000_0100;
    bus.hi_we = 1; bus.wdata = 32'h0000_ABCD;
    push(32'h0000_0012, 32'h3456_7800, 1'b0);
    step();
    bus.start = 0; bus.hi_we = 0;
    chk("hi_we_with_start", bus.hi, 32'h0000_ABCD);
    repeat (36) step();

    // Flush in cycle 10; mtlo during busy is ignored.
    bus.start = 1; bus.op = 2'b00; bus.a = 7; bus.b = 7;
    step();
    bus.start = 0;
    repeat (2) step();
    bus.lo_we = 1; bus.wdata = 32'h0000_DEAD;
    step();
    bus.lo_we = 0;
    repeat (6) step();
    bus.flush = 1;
    step();
    bus.flush = 0;
    chk("flush_busy", {31'b0, bus.busy}, '0);
    chk("flush_hi", bus.hi, 32'h0000_0012);
    chk("flush_lo", bus.lo, 32'h3456_7800);
    repeat (40) step();

    // Flush together with start in IDLE: nothing launched.
    bus.start = 1; bus.flush = 1; bus.op = 2'b00; bus.a = 1; bus.b = 1;
    step();
    bus.start = 0; bus.flush = 0;
    chk("flush_start_busy", {31'b0, bus.busy}, '0);
    repeat (40) step();

`ifdef MULDIV_UNSIGNED_EN
    issue(2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0);
    issue(2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b0);
`else
    issue(2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);
    issue(2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);
`endif
    repeat (3) step();

    chk("scoreboard_drained", sbq.size(), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
